// File: rtl/mem_stream_reader_pkg.sv
// Shared types and constants for the memory stream reader.
// Holds the FSM encoding, memory geometry and read-latency constants.
package mem_stream_reader_pkg;

    localparam int unsigned MEM_WORDS  = 1024;
    localparam int unsigned RD_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mem_stream_reader_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// Push and pop may coincide; a pop on an empty FIFO is ignored.
module sync_fifo
    import mem_stream_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            push_data_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            head_o,
    output logic [cnt_width(DEPTH)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_c;
    logic             do_pop_c;

    always_comb begin
        do_pop_c  = pop_i && (count_q != '0);
        do_push_c = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_stream_reader.sv
// Avalon-MM read master draining a block of on-chip RAM words into a
// valid/ready stream, with a credit-limited show-ahead output FIFO.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int unsigned ADDR_W     = $clog2(MEM_WORDS),
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic              avm_clken,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = cnt_width(FIFO_DEPTH);
    localparam int unsigned CRD_W  = CNT_W + 1;
    localparam int unsigned WORD_W = DATA_W + 1;

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cs_q, cs_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      issued_q, issued_d;
    logic [LEN_W-1:0]      accepted_q, accepted_d;
    logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;

    logic                  inflight_c;
    logic                  pop_c;
    logic [CRD_W-1:0]      credit_c;
    logic [WORD_W-1:0]     push_word_c;
    logic [WORD_W-1:0]     head_c;
    logic [CNT_W-1:0]      fifo_count_c;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_c),
        .push_data_i (push_word_c),
        .pop_i       (pop_c),
        .head_o      (head_c),
        .count_o     (fifo_count_c)
    );

    // Words already buffered, still on the bus, or being requested this cycle.
    always_comb begin
        inflight_c  = rd_pipe_q[RD_LATENCY-1];
        pop_c       = out_valid && out_ready;
        credit_c    = CRD_W'(fifo_count_c) + CRD_W'($countones(rd_pipe_q))
                    + CRD_W'(cs_q) - CRD_W'(pop_c);
        push_word_c = {accepted_q == (len_q - LEN_W'(1)), avm_readdata};
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cs_d       = 1'b0;
        addr_d     = addr_q;
        base_d     = base_q;
        len_d      = len_q;
        issued_d   = issued_q;
        accepted_d = inflight_c ? accepted_q + LEN_W'(1) : accepted_q;
        rd_pipe_d  = RD_LATENCY'({rd_pipe_q, cs_q});

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    len_d      = length;
                    issued_d   = '0;
                    accepted_d = '0;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // First read goes out in the cycle right after start.
                        cs_d     = 1'b1;
                        addr_d   = base_addr;
                        issued_d = LEN_W'(1);
                        busy_d   = 1'b1;
                        state_d  = (length == LEN_W'(1)) ? ST_DRAIN : ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (credit_c < CRD_W'(FIFO_DEPTH)) begin
                    cs_d     = 1'b1;
                    addr_d   = base_q + issued_q[ADDR_W-1:0];
                    issued_d = issued_q + LEN_W'(1);
                    if (issued_d == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop_c && out_last) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_q       <= 1'b0;
            addr_q     <= '0;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            rd_pipe_q  <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cs_q       <= cs_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            rd_pipe_q  <= rd_pipe_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write      = 1'b0;
    assign avm_byteenable = 4'hF;
    assign avm_clken      = 1'b1;
    assign out_valid      = (fifo_count_c != '0);
    assign out_data       = head_c[DATA_W-1:0];
    assign out_last       = head_c[DATA_W] && out_valid;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader: table of blocks plus random
// blocks, each checked against a word-level model of the expected stream.
module tb_mem_stream_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int WORDS  = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic              avm_clken;
    logic [DATA_W-1:0] avm_readdata = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    int checks   = 0;
    int failures = 0;

    mem_stream_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_byteenable (avm_byteenable),
        .avm_clken      (avm_clken),
        .avm_readdata   (avm_readdata),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last)
    );

    always #5 clk = ~clk;

    // Memory slave: word k holds k + 0x100, one-cycle read latency.
    always @(posedge clk) begin
        if (avm_chipselect) avm_readdata <= 32'(avm_address) + 32'h100;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int word_at(input int base, input int i);
        return ((base + i) % WORDS) + 32'h100;
    endfunction

    // Run one block from the current cycle (which becomes edge 0).
    // mode: 0 ready high, 1 random ready, 2 ready low for 20 cycles then toggling.
    task automatic run_block(input int base, input int len, input int mode, input bit poke,
                             input int exp_first, input int exp_lastw, input int exp_done);
        int addr_q[$];
        int reads = 0, hs = 0, max_out = 0, first_valid = -1, done_cyc = -1;
        int stall_reads = 0, last_hs = -1, first_word = -1, last_word = -1;
        int budget = len * 8 + 60;
        bit held = 1'b0;
        logic [31:0] held_data = '0;

        start     = 1'b1;
        base_addr = ADDR_W'(base);
        length    = (ADDR_W+1)'(len);
        step();
        start     = 1'b0;
        base_addr = ADDR_W'($urandom);
        length    = (ADDR_W+1)'($urandom);

        for (int n = 1; n <= budget; n++) begin
            start = poke && (n == 3);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (n > 20) ? 1'(n % 2) : 1'b0;
            endcase
            if (n == 1) begin
                check("busy_cycle1", 32'(busy), 32'(len != 0));
                check("cs_cycle1", 32'(avm_chipselect), 32'(len != 0));
            end
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, held_data);
            end
            if (avm_chipselect) begin
                reads++;
                addr_q.push_back(int'(avm_address));
                if (mode == 2 && n <= 20) stall_reads++;
            end
            if (reads - hs > max_out) max_out = reads - hs;
            if (out_valid && first_valid < 0) first_valid = n;
            if (out_valid && out_ready) begin
                check("data", out_data, 32'(word_at(base, hs)));
                check("last", 32'(out_last), 32'(hs == len - 1));
                if (hs == 0) first_word = int'(out_data);
                last_word = int'(out_data);
                last_hs = n;
                hs++;
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            if (done) begin
                done_cyc = n;
                check("busy_in_done", 32'(busy), 32'd0);
                if (len > 0) check("done_after_last", 32'(n), 32'(last_hs + 1));
                break;
            end
            step();
        end
        start = 1'b0;

        check("done_seen", 32'(done_cyc >= 0), 32'd1);
        check("word_count", 32'(hs), 32'(len));
        check("read_count", 32'(reads), 32'(len));
        check("outstanding_le_depth", 32'(max_out <= DEPTH), 32'd1);
        for (int i = 0; i < addr_q.size() && i < len; i++) begin
            check("read_addr", 32'(addr_q[i]), 32'((base + i) % WORDS));
        end
        if (len == 0) check("no_valid", 32'(first_valid), 32'hFFFF_FFFF);
        if (len > 0 && mode == 0) check("first_valid_cycle", 32'(first_valid), 32'd3);
        if (mode == 2) check("reads_before_stall", 32'(stall_reads), 32'((len < DEPTH) ? len : DEPTH));
        if (exp_first >= 0) check("first_word", 32'(first_word), 32'(exp_first));
        if (exp_lastw >= 0) check("last_word", 32'(last_word), 32'(exp_lastw));
        if (exp_done >= 0) check("done_cycle", 32'(done_cyc), 32'(exp_done));
    endtask

    typedef struct {
        int base;
        int len;
        int mode;
        bit poke;
        int exp_first;
        int exp_lastw;
        int exp_done;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{5,    8,    0, 1'b0, 32'h105, 32'h10C, 11};
        vecs[1] = '{1020, 8,    0, 1'b1, 32'h4FC, 32'h103, 11};
        vecs[2] = '{0,    16,   2, 1'b0, 32'h100, 32'h10F, -1};
        vecs[3] = '{0,    0,    0, 1'b0, -1,      -1,      1};
        vecs[4] = '{1023, 1,    0, 1'b0, 32'h4FF, 32'h4FF, 4};
        vecs[5] = '{3,    1024, 1, 1'b1, 32'h103, 32'h102, -1};
        vecs[6] = '{10,   3,    0, 1'b0, 32'h10A, 32'h10C, 6};

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cs", 32'(avm_chipselect), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("tie_write", 32'(avm_write), 32'd0);
        check("tie_byteenable", 32'(avm_byteenable), 32'hF);
        check("tie_clken", 32'(avm_clken), 32'd1);
        reset = 1'b0;
        step();

        // Back-to-back blocks: each new start lands in the previous done cycle.
        for (int v = 0; v < 7; v++) begin
            run_block(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].poke,
                      vecs[v].exp_first, vecs[v].exp_lastw, vecs[v].exp_done);
        end

        for (int r = 0; r < 8; r++) begin
            int b, l, m;
            b = $urandom_range(0, WORDS - 1);
            l = $urandom_range(1, 40);
            m = $urandom_range(0, 2);
            run_block(b, l, m, 1'($urandom_range(0, 1)), word_at(b, 0), word_at(b, l - 1),
                      (m == 0) ? l + 3 : -1);
        end

        // Reset in the middle of a stalled transfer with words buffered.
        step();
        out_ready = 1'b0;
        start     = 1'b1;
        base_addr = ADDR_W'(100);
        length    = (ADDR_W+1)'(16);
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_cs", 32'(avm_chipselect), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_addr", 32'(avm_address), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        step();
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("post_rst_no_done", 32'(done), 32'd0);
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
            step();
        end
        run_block(0, 2, 0, 1'b0, 32'h100, 32'h101, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
